// File: rtl/dut_response_capture.sv
// Response capture: samples DUT pins at a programmed strobe tick and compares them against a masked expected vector.
// Accumulates pass/fail results. Defining FAIL_PIN_LOG_EN adds a sticky per-pin fail map on FAIL_PINS.
module dut_response_capture #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PERFORM_TEST,
  input  logic             CLEAR_RESULTS,
  input  logic [WIDTH-1:0] BUS128,
  input  logic             EXP_LOAD,
  input  logic             EXP_TRANSFER,
  input  logic             MASK_LOAD,
  input  logic             MASK_TRANSFER,
  input  logic [7:0]       CYCLE_LENGTH,
  input  logic [6:0]       STROBE_TIME,
  input  logic [WIDTH-1:0] DUT_PINS,
  output logic [WIDTH-1:0] CAPTURE,
  output logic             STROBE_DONE,
  output logic             FAIL_FLAG,
  output logic [CNT_W-1:0] FAIL_COUNT,
  output logic [CNT_W-1:0] FIRST_FAIL_VECTOR,
  output logic [CNT_W-1:0] VECTOR_INDEX,
  output logic [WIDTH-1:0] FAIL_PINS
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    COMPARE = 2'd2
  } state_e;

  state_e           state_q;
  logic [7:0]       tick_q;
  logic [7:0]       len_q;
  logic [WIDTH-1:0] exp_pre_q, exp_act_q;
  logic [WIDTH-1:0] mask_pre_q, mask_act_q;
  logic [WIDTH-1:0] capture_q;
  logic [CNT_W-1:0] vec_idx_q;
  logic [CNT_W-1:0] strobe_idx_q;
  logic [CNT_W-1:0] fail_count_q;
  logic [CNT_W-1:0] first_fail_q;
  logic             fail_flag_q;
  logic             strobe_done_q;

  logic             running;
  logic             wrap;
  logic             strobe;
  logic [WIDTH-1:0] mismatch;
  logic             mismatch_any;

  // len_q is the cycle length latched at run start and at each wrap
  assign running      = PERFORM_TEST && (len_q != 8'd0);
  assign wrap         = (tick_q == (len_q - 8'd1));
  assign strobe       = (tick_q == {1'b0, STROBE_TIME});
  assign mismatch     = (capture_q ^ exp_act_q) & mask_act_q;
  assign mismatch_any = |mismatch;

  // Double-buffered expected/mask registers; simultaneous load+transfer moves the old pre-buffer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_pre_q  <= '0;
      exp_act_q  <= '0;
      mask_pre_q <= '0;
      mask_act_q <= '0;
    end else begin
      if (EXP_LOAD)      exp_pre_q  <= BUS128;
      if (EXP_TRANSFER)  exp_act_q  <= exp_pre_q;
      if (MASK_LOAD)     mask_pre_q <= BUS128;
      if (MASK_TRANSFER) mask_act_q <= mask_pre_q;
    end
  end

  // Test-cycle sequencer: tick/vector counting, strobe capture and compare scheduling
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      len_q        <= '0;
      vec_idx_q    <= '0;
      strobe_idx_q <= '0;
      capture_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tick_q <= '0;
          if (PERFORM_TEST && (CYCLE_LENGTH != 8'd0)) begin
            state_q <= RUN;
            len_q   <= CYCLE_LENGTH;
          end
        end
        default: begin
          if (!running) begin
            state_q <= IDLE;
            tick_q  <= '0;
          end else begin
            state_q <= strobe ? COMPARE : RUN;
            if (strobe) begin
              capture_q    <= DUT_PINS;
              strobe_idx_q <= vec_idx_q;
            end
            if (wrap) begin
              tick_q    <= '0;
              len_q     <= CYCLE_LENGTH;
              vec_idx_q <= vec_idx_q + CNT_W'(1);
            end else begin
              tick_q <= tick_q + 8'd1;
            end
          end
        end
      endcase
      if (CLEAR_RESULTS) vec_idx_q <= '0;
    end
  end

  // Result accumulation; a clear wins over a coinciding compare
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      strobe_done_q <= 1'b0;
      fail_flag_q   <= 1'b0;
      fail_count_q  <= '0;
      first_fail_q  <= '0;
    end else begin
      strobe_done_q <= (state_q == COMPARE);
      if (CLEAR_RESULTS) begin
        fail_flag_q  <= 1'b0;
        fail_count_q <= '0;
        first_fail_q <= '0;
      end else if ((state_q == COMPARE) && mismatch_any) begin
        fail_flag_q <= 1'b1;
        if (fail_count_q != '1) fail_count_q <= fail_count_q + CNT_W'(1);
        if (!fail_flag_q) first_fail_q <= strobe_idx_q;
      end
    end
  end

`ifdef FAIL_PIN_LOG_EN
  logic [WIDTH-1:0] fail_pins_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fail_pins_q <= '0;
    end else if (CLEAR_RESULTS) begin
      fail_pins_q <= '0;
    end else if (state_q == COMPARE) begin
      fail_pins_q <= fail_pins_q | mismatch;
    end
  end

  assign FAIL_PINS = fail_pins_q;
`else
  assign FAIL_PINS = '0;
`endif

  assign CAPTURE           = capture_q;
  assign STROBE_DONE       = strobe_done_q;
  assign FAIL_FLAG         = fail_flag_q;
  assign FAIL_COUNT        = fail_count_q;
  assign FIRST_FAIL_VECTOR = first_fail_q;
  assign VECTOR_INDEX      = vec_idx_q;

endmodule

// File: tb/tb_dut_response_capture.sv
// Bench for dut_response_capture: directed scenarios plus randomized runs against a timeline-based reference model.
module tb_dut_response_capture;

  logic         CLK;
  logic         RST;
  logic         PERFORM_TEST;
  logic         CLEAR_RESULTS;
  logic [127:0] BUS128;
  logic         EXP_LOAD, EXP_TRANSFER, MASK_LOAD, MASK_TRANSFER;
  logic [7:0]   CYCLE_LENGTH;
  logic [6:0]   STROBE_TIME;
  logic [127:0] DUT_PINS;
  logic [127:0] CAPTURE;
  logic         STROBE_DONE;
  logic         FAIL_FLAG;
  logic [15:0]  FAIL_COUNT;
  logic [15:0]  FIRST_FAIL_VECTOR;
  logic [15:0]  VECTOR_INDEX;
  logic [127:0] FAIL_PINS;

  dut_response_capture dut (
    .CLK(CLK), .RST(RST), .PERFORM_TEST(PERFORM_TEST), .CLEAR_RESULTS(CLEAR_RESULTS),
    .BUS128(BUS128), .EXP_LOAD(EXP_LOAD), .EXP_TRANSFER(EXP_TRANSFER),
    .MASK_LOAD(MASK_LOAD), .MASK_TRANSFER(MASK_TRANSFER),
    .CYCLE_LENGTH(CYCLE_LENGTH), .STROBE_TIME(STROBE_TIME), .DUT_PINS(DUT_PINS),
    .CAPTURE(CAPTURE), .STROBE_DONE(STROBE_DONE), .FAIL_FLAG(FAIL_FLAG),
    .FAIL_COUNT(FAIL_COUNT), .FIRST_FAIL_VECTOR(FIRST_FAIL_VECTOR),
    .VECTOR_INDEX(VECTOR_INDEX), .FAIL_PINS(FAIL_PINS)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [127:0] m_exp, m_mask, m_pins;
  logic         m_flag;
  int           m_count;
  logic [15:0]  m_first;
  int           m_base;
  logic [127:0] vec_pins [0:63];

  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] ONES = {128{1'b1}};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Vector index visible m clocks after run start; a clear at clock c restarts counting from 0
  function automatic logic [15:0] idx_at(input int m, input int L, input int c);
    if (c >= 0 && m >= c) return 16'(m / L - c / L);
    return 16'(m_base + m / L);
  endfunction

  task automatic check_results();
    logic [127:0] ep;
`ifdef FAIL_PIN_LOG_EN
    ep = m_pins;
`else
    ep = '0;
`endif
    check("fail_flag", 128'(FAIL_FLAG), 128'(m_flag));
    check("fail_count", 128'(FAIL_COUNT), 128'(m_count));
    check("first_fail", 128'(FIRST_FAIL_VECTOR), 128'(m_first));
    check("fail_pins", FAIL_PINS, ep);
  endtask

  task automatic load_exp(input logic [127:0] v);
    BUS128 = v; EXP_LOAD = 1'b1; clk1();
    EXP_LOAD = 1'b0; EXP_TRANSFER = 1'b1; clk1();
    EXP_TRANSFER = 1'b0;
    m_exp = v;
  endtask

  task automatic preload_exp(input logic [127:0] v);
    BUS128 = v; EXP_LOAD = 1'b1; clk1();
    EXP_LOAD = 1'b0;
  endtask

  task automatic load_mask(input logic [127:0] v);
    BUS128 = v; MASK_LOAD = 1'b1; clk1();
    MASK_LOAD = 1'b0; MASK_TRANSFER = 1'b1; clk1();
    MASK_TRANSFER = 1'b0;
    m_mask = v;
  endtask

  task automatic clear_res();
    CLEAR_RESULTS = 1'b1; clk1();
    CLEAR_RESULTS = 1'b0;
    m_flag = 1'b0; m_count = 0; m_first = '0; m_pins = '0; m_base = 0;
  endtask

  // Runs nvec test cycles from IDLE; vector v drives vec_pins[v%64]. Optional expected
  // transfer on the compare clock of vector xfer_vec, optional clear driven at iteration clr_m.
  task automatic run_vectors(input int L, input int S, input int nvec, input int xfer_vec,
                             input logic [127:0] new_exp, input int clr_m);
    int total, c, k, k1, v;
    bit exp_sd, cap_now;
    logic [127:0] mm;
    total = nvec * L;
    c = (clr_m >= 0) ? clr_m + 1 : -1;
    CYCLE_LENGTH = 8'(L); STROBE_TIME = 7'(S);
    DUT_PINS = vec_pins[0]; PERFORM_TEST = 1'b1;
    clk1();
    for (int m = 0; m <= total + 1; m++) begin
      check("vector_index", 128'(VECTOR_INDEX), 128'(idx_at((m > total) ? total : m, L, c)));
      k  = m - 2;
      k1 = m - 1;
      exp_sd  = (S < L) && (k >= 0) && (k < total) && ((k % L) == S);
      cap_now = (S < L) && (k1 >= 0) && (k1 < total) && ((k1 % L) == S);
      check("strobe_done", 128'(STROBE_DONE), 128'(exp_sd));
      if (cap_now) check("capture", CAPTURE, vec_pins[(k1 / L) % 64]);
      if (exp_sd) begin
        v  = k / L;
        mm = (vec_pins[v % 64] ^ m_exp) & m_mask;
        if (m != c && mm != '0) begin
          if (!m_flag) m_first = idx_at(k, L, c);
          m_flag = 1'b1;
          if (m_count < 65535) m_count++;
          m_pins = m_pins | mm;
        end
        if (v == xfer_vec) m_exp = new_exp;
      end
      if (m == c) begin
        m_flag = 1'b0; m_count = 0; m_first = '0; m_pins = '0;
      end
      if (exp_sd || m == c || m == total + 1) check_results();
      EXP_TRANSFER  = cap_now && ((k1 / L) == xfer_vec);
      CLEAR_RESULTS = (m == clr_m);
      if (m < total) DUT_PINS = vec_pins[(m / L) % 64];
      else PERFORM_TEST = 1'b0;
      clk1();
    end
    EXP_TRANSFER = 1'b0; CLEAR_RESULTS = 1'b0;
    m_base = int'(idx_at(total, L, c));
  endtask

  initial begin
    logic [127:0] x, y, ne;
    int L, S, nv, xv, cm;
    RST = 1'b1; PERFORM_TEST = 1'b0; CLEAR_RESULTS = 1'b0; BUS128 = '0;
    EXP_LOAD = 1'b0; EXP_TRANSFER = 1'b0; MASK_LOAD = 1'b0; MASK_TRANSFER = 1'b0;
    CYCLE_LENGTH = '0; STROBE_TIME = '0; DUT_PINS = '0;
    m_exp = '0; m_mask = '0; m_pins = '0; m_flag = 1'b0; m_count = 0; m_first = '0; m_base = 0;
    for (int i = 0; i < 64; i++) vec_pins[i] = A5;
    repeat (3) clk1();
    check("rst_capture", CAPTURE, '0);
    check("rst_strobe_done", 128'(STROBE_DONE), '0);
    check("rst_index", 128'(VECTOR_INDEX), '0);
    check_results();
    RST = 1'b0; clk1();

    // Clean run: 5 passing vectors
    load_exp(A5); load_mask(ONES);
    run_vectors(10, 4, 5, -1, '0, -1);
    check("t1_index", 128'(VECTOR_INDEX), 128'(16'd5));
    check("t1_count", 128'(FAIL_COUNT), '0);

    // Bit 7 flipped on vector 2
    clear_res();
    vec_pins[2] = A5 ^ 128'h80;
    run_vectors(10, 4, 5, -1, '0, -1);
    check("t2_flag", 128'(FAIL_FLAG), 128'(1'b1));
    check("t2_count", 128'(FAIL_COUNT), 128'(16'd1));
    check("t2_first", 128'(FIRST_FAIL_VECTOR), 128'(16'd2));
`ifdef FAIL_PIN_LOG_EN
    check("t2_pins", FAIL_PINS, 128'h80);
`endif

    // Masked-off pin, then an unmasked flip
    clear_res();
    load_mask(ONES ^ 128'h80);
    run_vectors(10, 4, 5, -1, '0, -1);
    check("t3_masked_count", 128'(FAIL_COUNT), '0);
    clear_res();
    vec_pins[2] = A5 ^ 128'h1;
    run_vectors(10, 4, 5, -1, '0, -1);
    check("t3_bit0_count", 128'(FAIL_COUNT), 128'(16'd1));

    // Expected transfer on a compare clock affects only later vectors
    clear_res();
    load_mask(ONES);
    vec_pins[2] = A5;
    preload_exp(A5 ^ 128'h1);
    run_vectors(10, 4, 4, 1, A5 ^ 128'h1, -1);
    check("t4_count", 128'(FAIL_COUNT), 128'(16'd2));
    check("t4_first", 128'(FIRST_FAIL_VECTOR), 128'(16'd2));

    // Simultaneous load+transfer: active receives the old pre-buffer
    clear_res();
    y = rand128(); x = rand128();
    preload_exp(y);
    BUS128 = x; EXP_LOAD = 1'b1; EXP_TRANSFER = 1'b1; clk1();
    EXP_LOAD = 1'b0; EXP_TRANSFER = 1'b0; m_exp = y;
    for (int i = 0; i < 2; i++) vec_pins[i] = y;
    run_vectors(3, 1, 2, -1, '0, -1);
    check("t4b_count", 128'(FAIL_COUNT), '0);
    EXP_TRANSFER = 1'b1; clk1(); EXP_TRANSFER = 1'b0; m_exp = x;
    run_vectors(3, 1, 2, -1, '0, -1);

    // Saturation over 65537 failing vectors (index wraps too)
    clear_res();
    load_exp('0);
    for (int i = 0; i < 64; i++) vec_pins[i] = rand128() | 128'h1;
    run_vectors(1, 0, 65537, -1, '0, -1);
    check("t5_saturated", 128'(FAIL_COUNT), 128'(16'hFFFF));

    // Clear coinciding with a failing compare (vector 1 compares 7 clocks in)
    clear_res();
    run_vectors(4, 1, 4, -1, '0, 6);

    // Strobe beyond the cycle: no compares, index still advances
    clear_res();
    run_vectors(10, 12, 3, -1, '0, -1);
    check("t6_index", 128'(VECTOR_INDEX), 128'(16'd3));

    // Randomized runs with accumulating results
    clear_res();
    for (int it = 0; it < 20; it++) begin
      L = $urandom_range(1, 12); S = $urandom_range(0, 13); nv = $urandom_range(2, 6);
      load_exp(rand128());
      load_mask(($urandom_range(0, 1) == 1) ? ONES : rand128());
      for (int i = 0; i < nv; i++) begin
        case ($urandom_range(0, 3))
          0: vec_pins[i] = m_exp ^ (128'(1) << $urandom_range(0, 127));
          1: vec_pins[i] = rand128();
          default: vec_pins[i] = m_exp;
        endcase
      end
      ne = rand128();
      preload_exp(ne);
      xv = $urandom_range(0, nv);
      cm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nv * L - 1)) : -1;
      run_vectors(L, S, nv, xv, ne, cm);
    end

    // Reset asserted mid-run clears everything immediately
    clear_res();
    load_exp(A5); load_mask(ONES);
    DUT_PINS = ~A5; CYCLE_LENGTH = 8'd10; STROBE_TIME = 7'd4; PERFORM_TEST = 1'b1;
    repeat (25) clk1();
    check("pre_rst_flag", 128'(FAIL_FLAG), 128'(1'b1));
    #3 RST = 1'b1;
    #1;
    check("mid_rst_capture", CAPTURE, '0);
    check("mid_rst_strobe_done", 128'(STROBE_DONE), '0);
    check("mid_rst_index", 128'(VECTOR_INDEX), '0);
    m_flag = 1'b0; m_count = 0; m_first = '0; m_pins = '0;
    check_results();
    PERFORM_TEST = 1'b0;
    clk1();
    RST = 1'b0;
    clk1();
    check("post_rst_index", 128'(VECTOR_INDEX), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
